link_drain: RTL

- Receiving end of the 3-bit buffer link protocol. Consumes strobed 2-bit payloads from a buffer's outSignal and stores them in a small FIFO.
- Returns a 3-bit response: ack, full, and sticky overflow.
- Exposes FIFO occupancy as a 4-bit state for the display block, and drains entries on a user pop request (KEY).

---
 rtl/link_drain.sv | 139 +++++++++++++
 1 files changed

// File: rtl/link_drain.sv
// Receiving end of the 3-bit buffer link: accepts strobed 2-bit payloads into a FIFO,
// answers with ack/full/overflow, drains on pop. Define SYNC_IN_EN to add 2-flop input synchronizers.
module link_drain #(
    parameter int DEPTH      = 8,
    parameter int ACK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] inSignal,
    input  logic       pop,
    output logic [2:0] outSignal,
    output logic [1:0] dataOut,
    output logic [3:0] state,
    output logic       LED
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic [2:0]    ack_cnt_q, ack_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          strb_q, pop_q;
    logic [1:0]    mem_q [DEPTH];

    logic strb_in, pop_in;
    logic strb_rise, pop_rise;
    logic full, empty, push, pop_do;

`ifdef SYNC_IN_EN
    logic [1:0] strb_sync_q, pop_sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strb_sync_q <= '0;
            pop_sync_q  <= '0;
        end else begin
            strb_sync_q <= {strb_sync_q[0], inSignal[0]};
            pop_sync_q  <= {pop_sync_q[0], pop};
        end
    end

    assign strb_in = strb_sync_q[1];
    assign pop_in  = pop_sync_q[1];
`else
    assign strb_in = inSignal[0];
    assign pop_in  = pop;
`endif

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        fsm_d     = fsm_q;
        ack_cnt_d = ack_cnt_q;
        ovf_d     = ovf_q;
        push      = 1'b0;

        full      = (count_q == 4'(DEPTH));
        empty     = (count_q == 4'd0);
        strb_rise = strb_in & ~strb_q;
        pop_rise  = pop_in & ~pop_q;
        pop_do    = pop_rise & ~empty;

        unique case (fsm_q)
            IDLE: begin
                if (strb_rise) begin
                    // A pop on the same edge frees the slot, so a full FIFO still accepts.
                    if (!full || pop_do) begin
                        push      = 1'b1;
                        fsm_d     = ACK;
                        ack_cnt_d = 3'(ACK_CYCLES);
                    end else begin
                        ovf_d = 1'b1;
                        fsm_d = WAIT_LOW;
                    end
                end
            end
            ACK: begin
                ack_cnt_d = ack_cnt_q - 3'd1;
                if (ack_cnt_q == 3'd1) fsm_d = strb_in ? WAIT_LOW : IDLE;
            end
            WAIT_LOW: begin
                if (!strb_in) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase

        wr_ptr_d = push   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_do ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        unique case ({push, pop_do})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q     <= IDLE;
            ack_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            strb_q    <= 1'b0;
            pop_q     <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            ack_cnt_q <= ack_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            strb_q    <= strb_in;
            pop_q     <= pop_in;
        end
    end

    // NOTE: storage is not reset; dataOut is masked to 2'b00 while empty so stale entries never show.
    // The payload is taken straight from the link since the sender holds it with the strobe.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= inSignal[2:1];
    end

    assign outSignal = {ovf_q, full, fsm_q == ACK};
    assign dataOut   = empty ? 2'b00 : mem_q[rd_ptr_q];
    assign state     = count_q;
    assign LED       = ~empty;

endmodule
